// File: rtl/mux_pkg.sv
// Shared types for the N-way registered select.
// Holds the storage state encoding and the widest beat layout.
package mux_pkg;

  localparam int MAX_N = 16;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  // Widest beat. Instances build the same layout
  // sized to their own WIDTH and SEL_W.
  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  sel;
    logic        err;
  } beat_max_t;

endpackage

// File: rtl/skid_buf.sv
// Two-entry valid/ready register with a skid slot.
// in_ready depends only on local state, never on out_ready.
import mux_pkg::*;

module skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  state_t       state;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;

  assign out_data = main_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_valid) begin
            main_q    <= in_data;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          unique case ({in_valid, out_ready})
            2'b11: main_q <= in_data;
            2'b10: begin
              skid_q   <= in_data;
              in_ready <= 1'b0;
              state    <= TWO;
            end
            2'b01: begin
              out_valid <= 1'b0;
              state     <= EMPTY;
            end
            default: ;
          endcase
        end
        TWO: begin
          if (out_ready) begin
            main_q   <= skid_q;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/muxn_pipe.sv
// N-way select with error flag feeding a skid buffer.
// Out-of-range selects produce zero data with sel_err set.
import mux_pkg::*;

module muxn_pipe #(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d [N],
  input  logic [SEL_W-1:0] s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic [SEL_W-1:0] sel_q,
  output logic             sel_err,
  output logic             out_valid,
  input  logic             out_ready
);

  if (N < 2 || N > MAX_N) begin : g_bad_n
    $error("muxn_pipe: N out of range");
  end

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             err;
  } beat_t;

  localparam int BW = $bits(beat_t);

  beat_t nxt;
  beat_t cur;
  logic [BW-1:0] cur_bits;

  always_comb begin
    nxt.data = '0;
    nxt.sel  = s;
    nxt.err  = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (s == SEL_W'(i)) begin
        nxt.data = d[i];
        nxt.err  = 1'b0;
      end
    end
  end

  skid_buf #(
    .W(BW)
  ) u_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (BW'(nxt)),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (cur_bits)
  );

  assign cur     = beat_t'(cur_bits);
  assign y       = cur.data;
  assign sel_q   = cur.sel;
  assign sel_err = cur.err;

endmodule

// File: tb/tb_muxn_pipe.sv
// Directed and scoreboard checks for muxn_pipe.
// Instance uses N=5 so out-of-range selects are reachable.
module tb_muxn_pipe;

  localparam int W = 32;
  localparam int N = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  d [N];
  logic [2:0]    s;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  y;
  logic [2:0]    sel_q;
  logic          sel_err;
  logic          out_valid;
  logic          out_ready;

  int total = 0;
  int bad   = 0;

  muxn_pipe #(
    .WIDTH(W),
    .N    (N)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .d        (d),
    .s        (s),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y        (y),
    .sel_q    (sel_q),
    .sel_err  (sel_err),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [35:0] q [$];
  logic [35:0] held;
  logic [35:0] obs;
  logic [35:0] mdl;
  logic        stalled;

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    s         = '0;
    d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33;
    d[3] = 32'h44; d[4] = 32'hABCD;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_sel", 64'(sel_q), 64'd0);
    chk("rst_err", 64'(sel_err), 64'd0);
    chk("rst_ir", 64'(in_ready), 64'd1);
    step();

    // back-to-back streaming
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s = 3'(i);
      step();
      chk("str_y", 64'(y), 64'((i + 1) * 32'h11));
      chk("str_ov", 64'(out_valid), 64'd1);
      chk("str_ir", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("str_end", 64'(out_valid), 64'd0);

    // stall fills skid
    out_ready = 1'b0;
    in_valid  = 1'b1;
    s = 3'd2;
    step();
    chk("stl_y0", 64'(y), 64'h33);
    chk("stl_ir0", 64'(in_ready), 64'd1);
    s = 3'd3;
    step();
    chk("stl_ir1", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    repeat (2) begin
      step();
      chk("stl_hold", 64'(y), 64'h33);
      chk("stl_ov", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    step();
    chk("stl_y1", 64'(y), 64'h44);
    chk("stl_ir2", 64'(in_ready), 64'd1);
    step();
    chk("stl_end", 64'(out_valid), 64'd0);

    // out-of-range select
    in_valid = 1'b1;
    s = 3'd6;
    step();
    chk("oor_y", 64'(y), 64'd0);
    chk("oor_err", 64'(sel_err), 64'd1);
    chk("oor_sel", 64'(sel_q), 64'd6);
    s = 3'd4;
    step();
    chk("in4_y", 64'(y), 64'hABCD);
    chk("in4_err", 64'(sel_err), 64'd0);
    chk("in4_sel", 64'(sel_q), 64'd4);
    in_valid = 1'b0;
    step();

    // reset with two beats held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    s = 3'd1;
    step();
    s = 3'd2;
    step();
    in_valid = 1'b0;
    chk("mr_full", 64'(in_ready), 64'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_ov", 64'(out_valid), 64'd0);
    chk("mr_y", 64'(y), 64'd0);
    chk("mr_sel", 64'(sel_q), 64'd0);
    chk("mr_ir", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (3) begin
      step();
      chk("mr_stale", 64'(out_valid), 64'd0);
    end

    // random scoreboard
    stalled = 1'b0;
    held    = '0;
    for (int c = 0; c < 3000; c++) begin
      obs = {sel_err, sel_q, y};
      chk("rnd_ov", 64'(out_valid), 64'(q.size() > 0));
      chk("rnd_ir", 64'(in_ready), 64'(q.size() < 2));
      if (stalled) chk("rnd_hold", 64'(obs), 64'(held));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      s = 3'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) d[i] = $urandom;
      if (out_valid && out_ready) begin
        if (q.size() > 0) begin
          chk("rnd_beat", 64'(obs), 64'(q[0]));
          void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        if (s < 3'(N)) mdl = {1'b0, s, d[s]};
        else mdl = {1'b1, s, 32'h0};
        q.push_back(mdl);
      end
      stalled = out_valid && !out_ready;
      held    = obs;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
